dcache_wb_direct: RTL and testbench
===================================

// Module: dcache_wb_direct
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and the backing data memory.
//  Serves word loads/stores in zero extra cycles on a hit. On a miss it raises a stall (mem_en & !hit) to the
//  hazard unit and runs a line write-back/refill FSM over a req/ack word-beat bus to the backing memory.
// PARAMETERS
//  DATA_WIDTH    32  word width
//  ADDR_WIDTH    10  word address width (byte addr >> 2)
//  INDEX_WIDTH    5  line index bits (32 lines)
//  OFFSET_WIDTH   3  word-in-line bits (8 words/line)
//  TAG_WIDTH      ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH (=2), derived, not overridable
// PORTS
//  clk        in   1           clock
//  rstn       in   1           async reset, active-low
//  addr       in   ADDR_WIDTH  CPU word address {tag,index,offset}; held stable by CPU while stalled
//  din        in   DATA_WIDTH  CPU store data
//  we         in   1           CPU store request (qualified by mem_en)
//  mem_en     in   1           CPU access valid this cycle
//  hit        out  1           access satisfied this cycle
//  dout       out  DATA_WIDTH  load data, valid when hit
//  mem_req    out  1           backing-memory beat request
//  mem_we     out  1           1 = write beat (write-back), 0 = read beat (refill)
//  mem_addr   out  ADDR_WIDTH  beat word address
//  mem_wdata  out  DATA_WIDTH  write-back data
//  mem_rdata  in   DATA_WIDTH  refill data, valid with mem_ack
//  mem_ack    in   1           beat complete; ignored while mem_req=0
//  miss_count out  16          misses taken since reset, saturating
// BEHAVIOUR
//  Storage: data[2^INDEX][2^OFFSET], tag[], valid[], dirty[] per line; only valid/dirty are reset.
//  Reset (async): state=IDLE, beat=0, all valid=0, dirty=0, miss_count=0; hit=0, mem_req=0, mem_we=0,
//   mem_addr=0, mem_wdata=0, dout=0. Reset mid-transfer aborts immediately; line contents are lost.
//  hit = (state==IDLE) & mem_en & valid[idx] & (tag[idx]==addr.tag), combinational.
//  dout = data[idx][off] when hit, else 0, combinational (0-cycle load latency).
//  Store hit: data[idx][off]<=din and dirty[idx]<=1 at the same posedge.
//  FSM states IDLE, WBACK, REFILL, FILL_DONE:
//   IDLE:    mem_en & !hit -> WBACK if valid&dirty, else REFILL; beat<=0; miss_count+=1 (saturates at 16'hFFFF).
//   WBACK:   mem_req=1, mem_we=1, mem_addr={tag[idx],idx,beat}, mem_wdata=data[idx][beat];
//            on mem_ack beat+=1; ack on beat=2^OFFSET-1 -> REFILL, beat<=0.
//   REFILL:  mem_req=1, mem_we=0, mem_addr={addr.tag,idx,beat}; on mem_ack data[idx][beat]<=mem_rdata,
//            beat+=1; ack on last beat -> FILL_DONE.
//   FILL_DONE: valid[idx]<=1, tag[idx]<=addr.tag, dirty[idx]<=0 -> IDLE.
//  Miss penalty = 1 (IDLE) + beats + 1 (FILL_DONE); hit asserts the first IDLE cycle after FILL_DONE.
//  Store miss: write-allocate; the store commits on that first hit cycle (sets dirty).
//  Requests are level-held: mem_addr/mem_we/mem_wdata stable until mem_ack; mem_ack may come the same cycle
//   as mem_req (1 beat/cycle max). mem_ack with mem_req=0 has no effect.
//  mem_en dropping mid-miss: transfer still completes to IDLE; hit stays 0 while mem_en=0.
//  Beat counter wraps only via FSM; never exceeds 2^OFFSET-1. CPU must not change addr while stalled.
// TESTING
//  1 Cold load addr=10'h044, memory preloaded word i = 32'hA000_0000+i, mem_ack every cycle -> 8 read beats
//    at 10'h040..047, hit after 10 cycles, dout=32'hA000_0044, miss_count=1; repeat load -> hit same cycle.
//  2 Store hit addr=10'h044 din=32'hDEAD_BEEF -> next load dout=DEAD_BEEF, dirty set, no mem_req.
//  3 Conflict load addr=10'h144 (same idx, tag 1) -> 8 write beats 10'h040..047 incl. DEAD_BEEF at 10'h044,
//    then 8 read beats 10'h140..147, miss_count=2.
//  4 Store miss addr=10'h2C8 din=32'h1234_5678 -> clean refill, store commits on hit cycle, reload returns 1234_5678.
//  5 mem_ack delayed 3 cycles per beat -> mem_addr/mem_wdata held stable, hit stays 0 until FILL_DONE+1.
//  6 rstn low during REFILL beat 4 -> mem_req=0 immediately, valid cleared, next access to same addr misses.

Source files
------------

// File: rtl/dcache_wb_direct.sv
// dcache_wb_direct
//   Direct-mapped, write-back, write-allocate data cache sitting between the
//   CPU MEM stage and the backing data memory. Hits are served combinationally
//   (zero extra cycles). A miss stalls the CPU (mem_en & !hit) while the FSM
//   writes back a dirty victim line and refills the line one word per beat
//   over a level-held req/ack bus.
//
//   Ports
//     clk, rstn            clock, asynchronous active-low reset
//     addr                 CPU word address {tag, index, offset}
//     din, we, mem_en      CPU store data, store request, access valid
//     hit, dout            access satisfied this cycle, load data (0 when !hit)
//     mem_req, mem_we      backing-memory beat request, 1 = write-back beat
//     mem_addr, mem_wdata  beat word address, write-back data
//     mem_rdata, mem_ack   refill data, beat complete
//     miss_count           saturating count of misses since reset
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | serving hits; a miss picks WBACK (dirty victim) or REFILL
//   S_WBACK   | writing the victim line back, one word per acked beat
//   S_REFILL  | reading the new line, one word per acked beat
//   S_FILL_DONE | install tag, mark line valid and clean
module dcache_wb_direct #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int INDEX_WIDTH  = 5,
  parameter int OFFSET_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  we,
  input  logic                  mem_en,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [15:0]           miss_count
);

  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int WORDS     = 1 << OFFSET_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WBACK,
    S_REFILL,
    S_FILL_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [DATA_WIDTH-1:0]   r_data [LINES*WORDS];
  logic [TAG_WIDTH-1:0]    r_tag  [LINES];
  logic [LINES-1:0]        r_valid;
  logic [LINES-1:0]        r_dirty;
  logic [OFFSET_WIDTH-1:0] r_beat;
  logic [15:0]             r_miss_count;

  logic [TAG_WIDTH-1:0]    w_tag;
  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [OFFSET_WIDTH-1:0] w_off;
  logic                    w_hit;
  logic                    w_store_hit;
  logic                    w_miss;
  logic                    w_last_beat;
  logic                    w_beat_clr;
  logic                    w_beat_inc;
  logic                    w_fill_wr;

  logic                              w_wr_en;
  logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] w_wr_addr;
  logic [DATA_WIDTH-1:0]             w_wr_data;

  assign w_tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign w_idx = addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign w_off = addr[OFFSET_WIDTH-1:0];

  assign w_hit       = (r_state == S_IDLE) & mem_en & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_store_hit = w_hit & we;
  assign w_miss      = (r_state == S_IDLE) & mem_en & ~w_hit;
  assign w_last_beat = (r_beat == '1);

  assign hit        = w_hit;
  assign dout       = w_hit ? r_data[{w_idx, w_off}] : '0;
  assign miss_count = r_miss_count;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_beat_clr   = 1'b0;
    w_beat_inc   = 1'b0;
    w_fill_wr    = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_miss) begin
          w_next_state = (r_valid[w_idx] & r_dirty[w_idx]) ? S_WBACK : S_REFILL;
          w_beat_clr   = 1'b1;
        end
      end
      S_WBACK: begin
        // Victim address is rebuilt from the stored tag, not the CPU tag.
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx, r_beat};
        mem_wdata = r_data[{w_idx, r_beat}];
        if (mem_ack) begin
          w_beat_inc = 1'b1;
          if (w_last_beat) begin
            w_next_state = S_REFILL;
            w_beat_clr   = 1'b1;
          end
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, r_beat};
        if (mem_ack) begin
          w_beat_inc = 1'b1;
          w_fill_wr  = 1'b1;
          if (w_last_beat) begin
            w_next_state = S_FILL_DONE;
          end
        end
      end
      S_FILL_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // The last refill beat increments r_beat from all-ones back to zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat <= '0;
    end else if (w_beat_clr) begin
      r_beat <= '0;
    end else if (w_beat_inc) begin
      r_beat <= r_beat + OFFSET_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_miss_count <= '0;
    end else if (w_miss && (r_miss_count != 16'hFFFF)) begin
      r_miss_count <= r_miss_count + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Line state and storage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == S_FILL_DONE) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (w_store_hit) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_FILL_DONE) begin
      r_tag[w_idx] <= w_tag;
    end
  end

  // Store hits and refill beats never coincide (hit requires S_IDLE).
  assign w_wr_en   = w_store_hit | w_fill_wr;
  assign w_wr_addr = w_store_hit ? {w_idx, w_off} : {w_idx, r_beat};
  assign w_wr_data = w_store_hit ? din : mem_rdata;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_data[w_wr_addr] <= w_wr_data;
    end
  end

endmodule

// File: tb/tb_dcache_wb_direct.sv
// tb_dcache_wb_direct
//   Directed bench for dcache_wb_direct. A behavioural backing memory
//   (word i preloaded with 32'hA000_0000 + i) answers beats after a
//   programmable delay, logs every completed beat and tracks whether the
//   request stays stable while waiting. Each test task drives one scenario
//   and compares against hand-computed values.
module tb_dcache_wb_direct;

  logic        clk;
  logic        rstn;
  logic [9:0]  addr;
  logic [31:0] din;
  logic        we;
  logic        mem_en;
  logic        hit;
  logic [31:0] dout;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [1024];
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  int          hold_err  = 0;
  bit          have_ref  = 0;
  logic [9:0]  ref_addr;
  logic        ref_we;
  logic [31:0] ref_wdata;

  logic [9:0]  log_addr [$];
  logic        log_we   [$];
  logic [31:0] log_data [$];

  dcache_wb_direct dut (
    .clk        (clk),
    .rstn       (rstn),
    .addr       (addr),
    .din        (din),
    .we         (we),
    .mem_en     (mem_en),
    .hit        (hit),
    .dout       (dout),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory: decides ack on the falling edge so the DUT sees it at
  // the next rising edge.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      have_ref = 1'b0;
    end else begin
      if (have_ref && (mem_addr !== ref_addr || mem_we !== ref_we ||
                       (mem_we && mem_wdata !== ref_wdata))) begin
        hold_err++;
      end
      if (!have_ref) begin
        ref_addr  = mem_addr;
        ref_we    = mem_we;
        ref_wdata = mem_wdata;
        have_ref  = 1'b1;
      end
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) mem[mem_addr] = mem_wdata;
        log_addr.push_back(mem_addr);
        log_we.push_back(mem_we);
        log_data.push_back(mem_we ? mem_wdata : mem[mem_addr]);
        wait_cnt = 0;
        have_ref = 1'b0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    log_addr.delete();
    log_we.delete();
    log_data.delete();
    hold_err = 0;
  endtask

  // One CPU access: waits (bounded) for hit, returns stall cycles and dout.
  task automatic do_access(input logic [9:0] a, input logic w, input logic [31:0] d,
                           output int cyc, output logic [31:0] rd);
    @(negedge clk);
    addr = a; we = w; din = d; mem_en = 1'b1;
    cyc = 0;
    #1;
    while (!hit && cyc < 300) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    rd = dout;
    @(posedge clk);
    #1;
    mem_en = 1'b0;
    we     = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; addr = 10'h044; we = 1'b0; din = '0; mem_en = 1'b1;
    #1;
    n_checks++; if (hit !== 1'b0)        begin n_fail++; $display("FAIL reset_hit got %b exp 0", hit); end
    n_checks++; if (mem_req !== 1'b0)    begin n_fail++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    n_checks++; if (mem_addr !== 10'h0)  begin n_fail++; $display("FAIL reset_mem_addr got %h exp 000", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
    n_checks++; if (dout !== 32'h0)      begin n_fail++; $display("FAIL reset_dout got %h exp 0", dout); end
    n_checks++; if (miss_count !== 16'h0) begin n_fail++; $display("FAIL reset_miss_count got %0d exp 0", miss_count); end
    mem_en = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_cold_load();
    int cyc; logic [31:0] rd;
    clear_log();
    do_access(10'h044, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL cold_latency got %0d exp 10", cyc); end
    n_checks++; if (log_addr.size() !== 8) begin n_fail++; $display("FAIL cold_beats got %0d exp 8", log_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i >= log_addr.size() || log_addr[i] !== 10'(10'h040 + i) || log_we[i] !== 1'b0) begin
        n_fail++; $display("FAIL cold_beat%0d got %h exp %h read", i,
                           (i < log_addr.size()) ? log_addr[i] : 10'h3FF, 10'(10'h040 + i));
      end
    end
    n_checks++; if (rd !== 32'hA000_0044) begin n_fail++; $display("FAIL cold_dout got %h exp A0000044", rd); end
    n_checks++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL cold_miss_count got %0d exp 1", miss_count); end
    clear_log();
    do_access(10'h044, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL rehit_latency got %0d exp 0", cyc); end
    n_checks++; if (rd !== 32'hA000_0044) begin n_fail++; $display("FAIL rehit_dout got %h exp A0000044", rd); end
    n_checks++; if (miss_count !== 16'd1) begin n_fail++; $display("FAIL rehit_miss_count got %0d exp 1", miss_count); end
  endtask

  task automatic test_store_hit();
    int cyc; logic [31:0] rd;
    clear_log();
    do_access(10'h044, 1'b1, 32'hDEAD_BEEF, cyc, rd);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL store_hit_latency got %0d exp 0", cyc); end
    do_access(10'h044, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL store_hit_dout got %h exp DEADBEEF", rd); end
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL store_reload_latency got %0d exp 0", cyc); end
    n_checks++; if (log_addr.size() !== 0) begin n_fail++; $display("FAIL store_hit_beats got %0d exp 0", log_addr.size()); end
    do_access(10'h043, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (rd !== 32'hA000_0043) begin n_fail++; $display("FAIL neighbour_dout got %h exp A0000043", rd); end
  endtask

  task automatic test_conflict_wb();
    int cyc; logic [31:0] rd; logic [31:0] exp_d;
    clear_log();
    do_access(10'h144, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (cyc !== 18) begin n_fail++; $display("FAIL conflict_latency got %0d exp 18", cyc); end
    n_checks++; if (log_addr.size() !== 16) begin n_fail++; $display("FAIL conflict_beats got %0d exp 16", log_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_d = (i == 4) ? 32'hDEAD_BEEF : 32'hA000_0040 + i;
      n_checks++;
      if (i >= log_addr.size() || log_addr[i] !== 10'(10'h040 + i) || log_we[i] !== 1'b1 || log_data[i] !== exp_d) begin
        n_fail++; $display("FAIL wb_beat%0d got %h/%h exp %h/%h write", i,
                           (i < log_addr.size()) ? log_addr[i] : 10'h3FF,
                           (i < log_data.size()) ? log_data[i] : 32'hX, 10'(10'h040 + i), exp_d);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (i + 8 >= log_addr.size() || log_addr[i+8] !== 10'(10'h140 + i) || log_we[i+8] !== 1'b0) begin
        n_fail++; $display("FAIL conflict_rd_beat%0d got %h exp %h read", i,
                           (i + 8 < log_addr.size()) ? log_addr[i+8] : 10'h3FF, 10'(10'h140 + i));
      end
    end
    n_checks++; if (mem[10'h044] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wb_mem_word got %h exp DEADBEEF", mem[10'h044]); end
    n_checks++; if (rd !== 32'hA000_0144) begin n_fail++; $display("FAIL conflict_dout got %h exp A0000144", rd); end
    n_checks++; if (miss_count !== 16'd2) begin n_fail++; $display("FAIL conflict_miss_count got %0d exp 2", miss_count); end
  endtask

  task automatic test_store_miss();
    int cyc; logic [31:0] rd; int n_wr;
    clear_log();
    do_access(10'h2C8, 1'b1, 32'h1234_5678, cyc, rd);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL store_miss_latency got %0d exp 10", cyc); end
    n_wr = 0;
    foreach (log_we[i]) if (log_we[i]) n_wr++;
    n_checks++; if (log_addr.size() !== 8 || n_wr !== 0) begin
      n_fail++; $display("FAIL store_miss_beats got %0d beats %0d writes exp 8/0", log_addr.size(), n_wr);
    end
    n_checks++; if (log_addr.size() > 0 && log_addr[0] !== 10'h2C8) begin
      n_fail++; $display("FAIL store_miss_first_addr got %h exp 2C8", log_addr[0]);
    end
    do_access(10'h2C8, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL store_miss_reload got %h exp 12345678", rd); end
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL store_miss_reload_lat got %0d exp 0", cyc); end
    n_checks++; if (miss_count !== 16'd3) begin n_fail++; $display("FAIL store_miss_count got %0d exp 3", miss_count); end
  endtask

  task automatic test_slow_ack();
    int cyc; logic [31:0] rd; logic [31:0] exp_d;
    ack_delay = 3;
    clear_log();
    do_access(10'h300, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (cyc !== 34) begin n_fail++; $display("FAIL slow_refill_latency got %0d exp 34", cyc); end
    n_checks++; if (rd !== 32'hA000_0300) begin n_fail++; $display("FAIL slow_refill_dout got %h exp A0000300", rd); end
    n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL slow_refill_hold got %0d changes exp 0", hold_err); end
    do_access(10'h301, 1'b1, 32'h5555_AAAA, cyc, rd);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL slow_store_latency got %0d exp 0", cyc); end
    clear_log();
    do_access(10'h001, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (cyc !== 66) begin n_fail++; $display("FAIL slow_wb_latency got %0d exp 66", cyc); end
    n_checks++; if (hold_err !== 0) begin n_fail++; $display("FAIL slow_wb_hold got %0d changes exp 0", hold_err); end
    n_checks++; if (log_addr.size() !== 16) begin n_fail++; $display("FAIL slow_wb_beats got %0d exp 16", log_addr.size()); end
    for (int i = 0; i < 8; i++) begin
      exp_d = (i == 1) ? 32'h5555_AAAA : 32'hA000_0300 + i;
      n_checks++;
      if (i >= log_data.size() || log_addr[i] !== 10'(10'h300 + i) || log_we[i] !== 1'b1 || log_data[i] !== exp_d) begin
        n_fail++; $display("FAIL slow_wb_beat%0d got %h exp %h", i,
                           (i < log_data.size()) ? log_data[i] : 32'hX, exp_d);
      end
    end
    n_checks++; if (rd !== 32'hA000_0001) begin n_fail++; $display("FAIL slow_wb_dout got %h exp A0000001", rd); end
    n_checks++; if (miss_count !== 16'd5) begin n_fail++; $display("FAIL slow_miss_count got %0d exp 5", miss_count); end
    ack_delay = 0;
  endtask

  task automatic test_reset_mid_refill();
    int cyc; int t; logic [31:0] rd;
    clear_log();
    @(negedge clk);
    addr = 10'h3A0; we = 1'b0; mem_en = 1'b1;
    t = 0;
    while (log_addr.size() < 4 && t < 100) begin
      @(posedge clk);
      t++;
    end
    n_checks++; if (t >= 100) begin n_fail++; $display("FAIL midreset_wait got timeout exp 4 beats"); end
    #1;
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 10'h3A4) begin
      n_fail++; $display("FAIL midreset_beat4 got req %b addr %h exp 1/3A4", mem_req, mem_addr);
    end
    rstn = 1'b0;
    #1;
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL midreset_mem_req got %b exp 0", mem_req); end
    n_checks++; if (miss_count !== 16'd0) begin n_fail++; $display("FAIL midreset_miss_count got %0d exp 0", miss_count); end
    n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL midreset_hit got %b exp 0", hit); end
    mem_en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (log_addr.size() !== 4) begin n_fail++; $display("FAIL midreset_beats got %0d exp 4", log_addr.size()); end
    rstn = 1'b1;
    clear_log();
    do_access(10'h3A0, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL postreset_latency got %0d exp 10", cyc); end
    n_checks++; if (rd !== 32'hA000_03A0) begin n_fail++; $display("FAIL postreset_dout got %h exp A00003A0", rd); end
    do_access(10'h144, 1'b0, 32'h0, cyc, rd);
    n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL postreset_old_line got %0d exp 10", cyc); end
    n_checks++; if (miss_count !== 16'd2) begin n_fail++; $display("FAIL postreset_miss_count got %0d exp 2", miss_count); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_cold_load();
    test_store_hit();
    test_conflict_wb();
    test_store_miss();
    test_slow_ack();
    test_reset_mid_refill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
